// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline forwarding/hazard logic: operand-mux
// select encodings, the hard-wired zero register and the MDU FSM states.
package pipe_pkg;

    // EX operand mux selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register 0 reads as zero and is never a real producer
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_t;

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks one outstanding multi-cycle MDU operation: busy window, final-cycle
// done pulse, latched destination and a sticky error for starts issued while
// the unit is still mid-operation.
module mdu_scoreboard
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mdu_start,
    input  logic [REG_AW-1:0] mdu_rd,
    output logic              mdu_busy,
    output logic              mdu_done,
    output logic              mdu_last,
    output logic [REG_AW-1:0] mdu_rd_q,
    output logic              mdu_err
);

    localparam int              CNT_W    = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

    mdu_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [REG_AW-1:0] r_rd_q;
    logic              r_err;
    logic              w_last;
    logic              w_accept;

    // The final busy cycle is the only point where a new op may be accepted
    // while running; it allows back-to-back issue with no idle gap.
    assign w_last   = (r_state == MDU_RUN) && (r_cnt == '0);
    assign w_accept = mdu_start && ((r_state == MDU_IDLE) || (r_cnt == '0));

    // FSM, countdown and destination latch; a new accept overrides the
    // natural return to IDLE on the final cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_rd_q  <= '0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, so evaluation order inside this block is irrelevant.
            if (w_accept) begin
                r_state <= MDU_RUN;
                r_cnt   <= CNT_LOAD;
                r_rd_q  <= mdu_rd;
            end else if (r_state == MDU_RUN) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end else begin
                    r_state <= MDU_IDLE;
                end
            end
            if (mdu_start && (r_state == MDU_RUN) && (r_cnt != '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mdu_busy = (r_state == MDU_RUN);
    assign mdu_done = w_last;
    assign mdu_last = w_last;
    assign mdu_rd_q = r_rd_q;
    assign mdu_err  = r_err;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage pipeline: per-channel EX operand
// mux selects, load-use / RAW / MDU stall generation, and the MDU scoreboard.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int MDU_LAT = 4,
    parameter int FWD_EN  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_mdu_op,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src_addr,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_regwrite,
    input  logic                      mdu_start,
    input  logic [REG_AW-1:0]         mdu_rd,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      bubble_ex,
    output logic                      mdu_busy,
    output logic                      mdu_done,
    output logic [REG_AW-1:0]         mdu_rd_q,
    output logic                      mdu_err
);

    localparam logic [REG_AW-1:0] ZERO_ADDR = REG_AW'(REG_ZERO);

    logic               w_mdu_busy;
    logic               w_mdu_last;
    logic [REG_AW-1:0]  w_mdu_rd_q;
    logic [NUM_SRC-1:0] w_src_hazard;
    logic               w_mdu_struct;

    mdu_scoreboard #(
        .REG_AW  (REG_AW),
        .MDU_LAT (MDU_LAT)
    ) u_mdu (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdu_start (mdu_start),
        .mdu_rd    (mdu_rd),
        .mdu_busy  (w_mdu_busy),
        .mdu_done  (mdu_done),
        .mdu_last  (w_mdu_last),
        .mdu_rd_q  (w_mdu_rd_q),
        .mdu_err   (mdu_err)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_AW-1:0] w_ex_a;
        logic [REG_AW-1:0] w_id_a;
        logic              w_mem_hit;
        logic              w_wb_hit;
        logic              w_id_live;
        logic              w_id_ex_hit;
        logic              w_id_mem_hit;
        logic              w_id_mdu_hit;

        assign w_ex_a = ex_src_addr[i*REG_AW +: REG_AW];
        assign w_id_a = id_src_addr[i*REG_AW +: REG_AW];

        // EX-stage forwarding: MEM is the younger producer and wins over WB
        assign w_mem_hit = mem_regwrite && (mem_rd != ZERO_ADDR) && (mem_rd == w_ex_a);
        assign w_wb_hit  = wb_regwrite  && (wb_rd  != ZERO_ADDR) && (wb_rd  == w_ex_a);

        if (FWD_EN != 0) begin : g_fwd
            assign fwd_sel[2*i +: 2] = w_mem_hit ? FWD_MEM : (w_wb_hit ? FWD_WB : FWD_RF);
        end else begin : g_nofwd
            assign fwd_sel[2*i +: 2] = FWD_RF;
        end

        // ID-stage hazards: only real, non-zero sources can create a dependency
        assign w_id_live    = id_src_used[i] && (w_id_a != ZERO_ADDR);
        assign w_id_ex_hit  = ex_regwrite  && (ex_rd  == w_id_a);
        assign w_id_mem_hit = mem_regwrite && (mem_rd == w_id_a);
        assign w_id_mdu_hit = w_mdu_busy   && (w_mdu_rd_q == w_id_a);

        if (FWD_EN != 0) begin : g_haz_fwd
            // Only a load in EX cannot be forwarded in time
            assign w_src_hazard[i] = w_id_live &&
                ((ex_memread && w_id_ex_hit) || w_id_mdu_hit);
        end else begin : g_haz_nofwd
            // Without forwarding any EX/MEM producer must retire first; WB is
            // covered by the write-before-read register file.
            assign w_src_hazard[i] = w_id_live &&
                (w_id_ex_hit || w_id_mem_hit || w_id_mdu_hit);
        end
    end

    // A second MDU op may only enter EX on the final busy cycle
    assign w_mdu_struct = w_mdu_busy && !w_mdu_last && id_mdu_op;

    // Combined stall, forced low while reset is held so the front end is free
    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            stall = (|w_src_hazard) || w_mdu_struct;
        end
    end

    assign bubble_ex = stall;
    assign mdu_busy  = w_mdu_busy;
    assign mdu_rd_q  = w_mdu_rd_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two instances (forwarding on/off)
// share one randomized stimulus stream; a reference model tracks the MDU by
// absolute cycle numbers and a monitor compares every cycle's outputs.
`timescale 1ns/1ps
module tb_fwd_hazard_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int MDU_LAT = 4;
    localparam int AW      = NUM_SRC * REG_AW;

    typedef struct {
        logic               rst_n;
        logic [AW-1:0]      id_src;
        logic [NUM_SRC-1:0] id_used;
        logic               id_mdu_op;
        logic [AW-1:0]      ex_src;
        logic [REG_AW-1:0]  ex_rd;
        logic               ex_rw;
        logic               ex_mr;
        logic [REG_AW-1:0]  mem_rd;
        logic               mem_rw;
        logic [REG_AW-1:0]  wb_rd;
        logic               wb_rw;
        logic               mdu_start;
        logic [REG_AW-1:0]  mdu_rd;
    } stim_t;

    typedef struct {
        logic [2*NUM_SRC-1:0] fwd_on;
        logic [2*NUM_SRC-1:0] fwd_off;
        logic                 stall_on;
        logic                 stall_off;
        logic                 busy;
        logic                 done;
        logic [REG_AW-1:0]    rdq;
        logic                 err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0]      id_src_addr, ex_src_addr;
    logic [NUM_SRC-1:0] id_src_used;
    logic               id_mdu_op, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, mdu_start;
    logic [REG_AW-1:0]  ex_rd, mem_rd, wb_rd, mdu_rd;

    logic [2*NUM_SRC-1:0] fwd_on, fwd_off;
    logic                 stall_on, stall_off, bub_on, bub_off;
    logic                 busy_on, busy_off, done_on, done_off, err_on, err_off;
    logic [REG_AW-1:0]    rdq_on, rdq_off;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MDU_LAT(MDU_LAT), .FWD_EN(1)) u_dut_fwd (
        .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_mdu_op(id_mdu_op), .ex_src_addr(ex_src_addr), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .mdu_start(mdu_start), .mdu_rd(mdu_rd), .fwd_sel(fwd_on),
        .stall(stall_on), .bubble_ex(bub_on), .mdu_busy(busy_on), .mdu_done(done_on),
        .mdu_rd_q(rdq_on), .mdu_err(err_on));

    fwd_hazard_unit #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MDU_LAT(MDU_LAT), .FWD_EN(0)) u_dut_nofwd (
        .clk(clk), .rst_n(rst_n), .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_mdu_op(id_mdu_op), .ex_src_addr(ex_src_addr), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .mdu_start(mdu_start), .mdu_rd(mdu_rd), .fwd_sel(fwd_off),
        .stall(stall_off), .bubble_ex(bub_off), .mdu_busy(busy_off), .mdu_done(done_off),
        .mdu_rd_q(rdq_off), .mdu_err(err_off));

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference MDU state: op occupies absolute cycles (issue+1)..m_end
    int                cyc      = 0;
    int                m_end    = -1;
    bit                m_active = 1'b0;
    logic [REG_AW-1:0] m_rdq    = '0;
    bit                m_err    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*NUM_SRC-1:0] model_fwd(input stim_t s, input bit en);
        logic [2*NUM_SRC-1:0] r = '0;
        for (int ch = 0; ch < NUM_SRC; ch++) begin
            logic [REG_AW-1:0] a = s.ex_src[ch*REG_AW +: REG_AW];
            if (en && s.mem_rw && s.mem_rd != 0 && s.mem_rd == a)     r[2*ch +: 2] = 2'b10;
            else if (en && s.wb_rw && s.wb_rd != 0 && s.wb_rd == a)   r[2*ch +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic logic model_stall(input stim_t s, input bit en, input bit busy,
                                         input bit final_cyc, input logic [REG_AW-1:0] rdq);
        logic hz = busy && !final_cyc && s.id_mdu_op;
        for (int ch = 0; ch < NUM_SRC; ch++) begin
            logic [REG_AW-1:0] a = s.id_src[ch*REG_AW +: REG_AW];
            if (s.id_used[ch] && a != 0) begin
                if (en) hz |= s.ex_mr && s.ex_rw && s.ex_rd == a;
                else    hz |= (s.ex_rw && s.ex_rd == a) || (s.mem_rw && s.mem_rd == a);
                hz |= busy && rdq == a;
            end
        end
        return s.rst_n && hz;
    endfunction

    // Drive one cycle, predict its outputs, then advance the model
    task automatic apply(input stim_t s);
        exp_t e;
        bit   busy_now, last_now;
        @(negedge clk);
        rst_n = s.rst_n; id_src_addr = s.id_src; id_src_used = s.id_used; id_mdu_op = s.id_mdu_op;
        ex_src_addr = s.ex_src; ex_rd = s.ex_rd; ex_regwrite = s.ex_rw; ex_memread = s.ex_mr;
        mem_rd = s.mem_rd; mem_regwrite = s.mem_rw; wb_rd = s.wb_rd; wb_regwrite = s.wb_rw;
        mdu_start = s.mdu_start; mdu_rd = s.mdu_rd;
        if (!s.rst_n) begin
            m_active = 1'b0; m_err = 1'b0; m_rdq = '0;
        end
        busy_now    = m_active && cyc <= m_end;
        last_now    = busy_now && cyc == m_end;
        e.fwd_on    = model_fwd(s, 1'b1);
        e.fwd_off   = model_fwd(s, 1'b0);
        e.stall_on  = model_stall(s, 1'b1, busy_now, last_now, m_rdq);
        e.stall_off = model_stall(s, 1'b0, busy_now, last_now, m_rdq);
        e.busy      = busy_now;
        e.done      = last_now;
        e.rdq       = m_rdq;
        e.err       = m_err;
        exp_q.push_back(e);
        if (s.rst_n && s.mdu_start) begin
            if (!busy_now || last_now) begin
                m_active = 1'b1; m_end = cyc + MDU_LAT; m_rdq = s.mdu_rd;
            end else begin
                m_err = 1'b1;
            end
        end
        cyc++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst_n = 1'b1; s.id_src = '0; s.id_used = '0; s.id_mdu_op = 1'b0; s.ex_src = '0;
        s.ex_rd = '0; s.ex_rw = 1'b0; s.ex_mr = 1'b0; s.mem_rd = '0; s.mem_rw = 1'b0;
        s.wb_rd = '0; s.wb_rw = 1'b0; s.mdu_start = 1'b0; s.mdu_rd = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        s.rst_n     = ($urandom_range(0, 149) != 0);
        for (int ch = 0; ch < NUM_SRC; ch++) begin
            s.id_src[ch*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
            s.ex_src[ch*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        end
        s.id_used   = NUM_SRC'($urandom);
        s.id_mdu_op = ($urandom_range(0, 3) == 0);
        s.ex_rd     = REG_AW'($urandom_range(0, 7));
        s.ex_rw     = 1'($urandom);
        s.ex_mr     = 1'($urandom);
        s.mem_rd    = REG_AW'($urandom_range(0, 7));
        s.mem_rw    = 1'($urandom);
        s.wb_rd     = REG_AW'($urandom_range(0, 7));
        s.wb_rw     = 1'($urandom);
        s.mdu_start = ($urandom_range(0, 3) == 0);
        s.mdu_rd    = REG_AW'($urandom_range(0, 7));
        return s;
    endfunction

    // Monitor: outputs are combinational every cycle, compared mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fwd_sel_fwd",    32'(fwd_on),    32'(e.fwd_on));
                check("fwd_sel_nofwd",  32'(fwd_off),   32'(e.fwd_off));
                check("stall_fwd",      32'(stall_on),  32'(e.stall_on));
                check("stall_nofwd",    32'(stall_off), 32'(e.stall_off));
                check("bubble_fwd",     32'(bub_on),    32'(e.stall_on));
                check("bubble_nofwd",   32'(bub_off),   32'(e.stall_off));
                check("mdu_busy",       32'(busy_on),   32'(e.busy));
                check("mdu_busy_nofwd", 32'(busy_off),  32'(e.busy));
                check("mdu_done",       32'(done_on),   32'(e.done));
                check("mdu_done_nofwd", 32'(done_off),  32'(e.done));
                check("mdu_rd_q",       32'(rdq_on),    32'(e.rdq));
                check("mdu_err",        32'(err_on),    32'(e.err));
                check("mdu_err_nofwd",  32'(err_off),   32'(e.err));
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        s = idle(); s.rst_n = 1'b0;
        apply(s); apply(s);

        // Forwarding priority MEM > WB, then WB only, then r0
        s = idle(); s.mem_rd = 5; s.mem_rw = 1; s.wb_rd = 5; s.wb_rw = 1; s.ex_src = {5'd5, 5'd5};
        apply(s);
        s.mem_rw = 0;             apply(s);
        s.ex_src = '0;            apply(s);

        // Load-use on channel 1, then same with the source unused
        s = idle(); s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 8; s.id_src = {5'd8, 5'd0}; s.id_used = 2'b10;
        apply(s);
        s.id_used = 2'b00;        apply(s);

        // RAW moving down EX -> MEM -> WB
        s = idle(); s.ex_rd = 3; s.ex_rw = 1; s.id_src = {5'd0, 5'd3}; s.id_used = 2'b01;
        apply(s);
        s.ex_rw = 0; s.mem_rd = 3; s.mem_rw = 1; apply(s);
        s.mem_rw = 0; s.wb_rd = 3; s.wb_rw = 1;  apply(s);

        // MDU op to r12 with a dependent ID instruction waiting on it
        s = idle(); s.mdu_start = 1; s.mdu_rd = 12; apply(s);
        s = idle(); s.id_src = {5'd0, 5'd12}; s.id_used = 2'b01;
        repeat (6) apply(s);

        // Back-to-back reload on the done cycle, then an illegal mid-op start
        s = idle(); s.mdu_start = 1; s.mdu_rd = 12; apply(s);
        s = idle(); s.id_mdu_op = 1; repeat (3) apply(s);
        s.mdu_start = 1; s.mdu_rd = 9; apply(s);
        s = idle(); repeat (4) apply(s);
        s = idle(); s.mdu_start = 1; s.mdu_rd = 4; apply(s);
        s = idle(); apply(s);
        s.mdu_start = 1; s.mdu_rd = 6; apply(s);
        s = idle(); repeat (6) apply(s);

        // Reset in the middle of an op
        s = idle(); s.mdu_start = 1; s.mdu_rd = 12; apply(s);
        s = idle(); s.id_src = {5'd12, 5'd12}; s.id_used = 2'b11; apply(s); apply(s);
        s.rst_n = 0; apply(s);
        s.rst_n = 1; repeat (6) apply(s);

        repeat (2000) apply(rand_stim());

        repeat (3) @(negedge clk);
        #3;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
